// File: rtl/g15_io_pkg.sv
// rtl/g15_io_pkg.sv - shared types and constants for the G-15 I/O device models
//
// Purpose: state encoding and frame constants used by the photoelectric
// tape reader model and its period counter.
// Ports: none (package).
package g15_io_pkg;

  localparam int PTR_FRAME_W = 5;
  localparam logic [PTR_FRAME_W-1:0] PTR_STOP_CODE = 5'b10000;

  typedef enum logic [2:0] {
    PTR_IDLE,
    PTR_FWD_WAIT,
    PTR_FWD_READ,
    PTR_FWD_DELIVER,
    PTR_REV_WAIT,
    PTR_REV_READ,
    PTR_REV_CHECK
  } ptr_state_t;

endpackage

// File: rtl/ptr_period_ctr.sv
// rtl/ptr_period_ctr.sv - loadable down-counter with terminal-count pulse
//
// Purpose: times the idle portion of a character period for both tape
// directions. The count is loaded with the number of wait cycles; tc is
// high on the last enabled cycle of that window.
// Ports:
//   CLOCK     in  1  system clock
//   rst       in  1  synchronous active-high reset
//   load      in  1  load load_val (has priority over en)
//   load_val  in  W  number of enabled cycles until tc
//   en        in  1  count down one per cycle
//   tc        out 1  terminal count, combinational from count and en
module ptr_period_ctr #(
  parameter int W = 8
) (
  input  logic         CLOCK,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);
  import g15_io_pkg::*;

  logic [W-1:0] count;

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // A load of N yields tc on the N-th enabled cycle after the load.
  assign tc = en && (count == W'(1));

endmodule

// File: rtl/ptr_reader.sv
// rtl/ptr_reader.sv - photoelectric tape reader device model
//
// Purpose: steps a tape image held in external RAM, delivering one 5-bit
// frame per character period while PL6_PHOTO_TAPE_FWD is held, and backing
// up one block on REV_REQ.
// Ports:
//   CLOCK               in  1       system clock
//   rst                 in  1       synchronous active-high reset
//   PL6_PHOTO_TAPE_FWD  in  1       run tape forward (level)
//   REV_REQ             in  1       reverse one block (level, sampled in idle)
//   TAPE_LOADED         in  1       image present in RAM
//   TAPE_LEN            in  ADDR_W  frames in image
//   MEM_ADDR            out ADDR_W  RAM read address
//   MEM_RD              out 1       read strobe, MEM_DATA valid next cycle
//   MEM_DATA            in  5       frame from RAM
//   PT_DATA             out 5       last delivered frame
//   PT_STROBE           out 1       pulse, PT_DATA newly valid
//   PT_STOP             out 1       pulse with PT_STROBE on a stop code
//   PL6_PHOTO_TAPE_REV  out 1       high throughout a reverse operation
//   PT_EOT              out 1       at end of tape or no tape
//   PT_POS              out ADDR_W  current tape position
module ptr_reader
  import g15_io_pkg::*;
#(
  parameter int                     CHAR_CLKS = 100,
  parameter int                     ADDR_W    = 16,
  parameter logic [PTR_FRAME_W-1:0] STOP_CODE = PTR_STOP_CODE
) (
  input  logic                   CLOCK,
  input  logic                   rst,
  input  logic                   PL6_PHOTO_TAPE_FWD,
  input  logic                   REV_REQ,
  input  logic                   TAPE_LOADED,
  input  logic [ADDR_W-1:0]      TAPE_LEN,
  output logic [ADDR_W-1:0]      MEM_ADDR,
  output logic                   MEM_RD,
  input  logic [PTR_FRAME_W-1:0] MEM_DATA,
  output logic [PTR_FRAME_W-1:0] PT_DATA,
  output logic                   PT_STROBE,
  output logic                   PT_STOP,
  output logic                   PL6_PHOTO_TAPE_REV,
  output logic                   PT_EOT,
  output logic [ADDR_W-1:0]      PT_POS
);

  localparam int CW = $clog2(CHAR_CLKS) + 1;
  // Wait cycles plus one read cycle plus one deliver/check cycle make a period.
  localparam logic [CW-1:0] WAIT_CLKS = CW'(CHAR_CLKS - 2);

  ptr_state_t        state;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] pos_inc;
  logic [ADDR_W-1:0] pos_dec;
  logic              first_step;
  logic              eot;
  logic              ctr_load;
  logic              ctr_en;
  logic              ctr_tc;

  assign eot     = !TAPE_LOADED || (pos >= TAPE_LEN);
  // Saturating neighbours of pos: never wrap past either end of the tape.
  assign pos_inc = (pos < TAPE_LEN) ? pos + ADDR_W'(1) : pos;
  assign pos_dec = (pos != '0) ? pos - ADDR_W'(1) : pos;

  // The counter is held at its reload value whenever a wait window is about
  // to begin, so entering either WAIT state always starts a fresh period.
  assign ctr_load = (state == PTR_IDLE) || (state == PTR_FWD_DELIVER) ||
                    (state == PTR_REV_CHECK);
  assign ctr_en   = (state == PTR_FWD_WAIT) || (state == PTR_REV_WAIT);

  ptr_period_ctr #(.W(CW)) u_period (
    .CLOCK    (CLOCK),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (WAIT_CLKS),
    .en       (ctr_en),
    .tc       (ctr_tc)
  );

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state              <= PTR_IDLE;
      pos                <= '0;
      first_step         <= 1'b0;
      MEM_ADDR           <= '0;
      MEM_RD             <= 1'b0;
      PT_DATA            <= '0;
      PT_STROBE          <= 1'b0;
      PT_STOP            <= 1'b0;
      PL6_PHOTO_TAPE_REV <= 1'b0;
    end else if (!TAPE_LOADED) begin
      // Tape removed: drop whatever frame was in flight and rewind.
      state              <= PTR_IDLE;
      pos                <= '0;
      first_step         <= 1'b0;
      MEM_RD             <= 1'b0;
      PT_STROBE          <= 1'b0;
      PT_STOP            <= 1'b0;
      PL6_PHOTO_TAPE_REV <= 1'b0;
    end else begin
      PT_STROBE <= 1'b0;
      PT_STOP   <= 1'b0;
      MEM_RD    <= 1'b0;
      case (state)
        PTR_IDLE: begin
          if (PL6_PHOTO_TAPE_FWD && !eot) begin
            state <= PTR_FWD_WAIT;
          end else if (REV_REQ && (pos != '0)) begin
            state              <= PTR_REV_WAIT;
            first_step         <= 1'b1;
            PL6_PHOTO_TAPE_REV <= 1'b1;
          end
        end
        PTR_FWD_WAIT: begin
          if (!PL6_PHOTO_TAPE_FWD) begin
            state <= PTR_IDLE;
          end else if (ctr_tc) begin
            // Issue the read here so the strobe is high during FWD_READ.
            state    <= PTR_FWD_READ;
            MEM_RD   <= 1'b1;
            MEM_ADDR <= pos;
          end
        end
        PTR_FWD_READ: begin
          state <= PTR_FWD_DELIVER;
        end
        PTR_FWD_DELIVER: begin
          PT_DATA   <= MEM_DATA;
          PT_STROBE <= 1'b1;
          PT_STOP   <= (MEM_DATA == STOP_CODE);
          pos       <= pos_inc;
          if (PL6_PHOTO_TAPE_FWD && (pos_inc < TAPE_LEN)) begin
            state <= PTR_FWD_WAIT;
          end else begin
            state <= PTR_IDLE;
          end
        end
        PTR_REV_WAIT: begin
          if (ctr_tc) begin
            state    <= PTR_REV_READ;
            MEM_RD   <= 1'b1;
            MEM_ADDR <= pos_dec;
          end
        end
        PTR_REV_READ: begin
          state <= PTR_REV_CHECK;
        end
        PTR_REV_CHECK: begin
          // The first step backs over the stop code that ended the block just
          // read; any later stop code marks the previous block's end.
          if ((MEM_DATA == STOP_CODE) && !first_step) begin
            state              <= PTR_IDLE;
            PL6_PHOTO_TAPE_REV <= 1'b0;
          end else begin
            first_step <= 1'b0;
            pos        <= pos_dec;
            if (pos_dec == '0) begin
              state              <= PTR_IDLE;
              PL6_PHOTO_TAPE_REV <= 1'b0;
            end else begin
              state <= PTR_REV_WAIT;
            end
          end
        end
        default: begin
          state              <= PTR_IDLE;
          PL6_PHOTO_TAPE_REV <= 1'b0;
        end
      endcase
    end
  end

  assign PT_EOT = eot;
  assign PT_POS = pos;

endmodule

// File: tb/tb_ptr_reader.sv
// tb/tb_ptr_reader.sv - self-checking bench for ptr_reader
module tb_ptr_reader;

  localparam int CC = 4;
  localparam int AW = 8;

  logic          CLOCK = 1'b0;
  logic          rst;
  logic          fwd;
  logic          rev_req;
  logic          loaded;
  logic [AW-1:0] len;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [4:0]    mem_data;
  logic [4:0]    pt_data;
  logic          pt_strobe;
  logic          pt_stop;
  logic          rev_o;
  logic          pt_eot;
  logic [AW-1:0] pt_pos;

  logic [4:0] img [0:255];
  logic [5:0] exp_q [$];
  int         strobe_cyc [$];
  int         cyc = 0;
  int         strobe_cnt = 0;
  int         rev_total = 0;
  int         checks = 0;
  int         errors = 0;

  ptr_reader #(.CHAR_CLKS(CC), .ADDR_W(AW), .STOP_CODE(5'b10000)) dut (
    .CLOCK              (CLOCK),
    .rst                (rst),
    .PL6_PHOTO_TAPE_FWD (fwd),
    .REV_REQ            (rev_req),
    .TAPE_LOADED        (loaded),
    .TAPE_LEN           (len),
    .MEM_ADDR           (mem_addr),
    .MEM_RD             (mem_rd),
    .MEM_DATA           (mem_data),
    .PT_DATA            (pt_data),
    .PT_STROBE          (pt_strobe),
    .PT_STOP            (pt_stop),
    .PL6_PHOTO_TAPE_REV (rev_o),
    .PT_EOT             (pt_eot),
    .PT_POS             (pt_pos)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_data <= img[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe must match the oldest expected frame.
  always @(negedge CLOCK) begin
    if (pt_strobe) begin
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(pt_strobe), 32'd0);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("frame_data", 32'(pt_data), 32'(e[4:0]));
        chk("frame_stop", 32'(pt_stop), 32'(e[5]));
      end
    end else if (pt_stop) begin
      chk("stop_without_strobe", 32'(pt_stop), 32'd0);
    end
    if (rev_o) rev_total++;
  end

  task automatic push_frame(input logic [4:0] d);
    exp_q.push_back({(d == 5'b10000), d});
  endtask

  task automatic wait_strobes(input int target, input string tag);
    int n;
    n = 0;
    while (strobe_cnt < target && n < 200) begin
      @(negedge CLOCK);
      #1;
      n++;
    end
    chk(tag, 32'(strobe_cnt >= target), 32'd1);
  endtask

  task automatic reload();
    @(posedge CLOCK); #1 loaded = 1'b0;
    @(posedge CLOCK); #1 loaded = 1'b1;
  endtask

  task automatic rev_measure(output int cycles);
    @(posedge CLOCK); #1 rev_req = 1'b1;
    @(posedge CLOCK); #1 rev_req = 1'b0;
    cycles = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge CLOCK);
      if (!rev_o) break;
      cycles++;
    end
  endtask

  initial begin
    int rc;
    int sc;
    int rt;
    bit hit;
    rst = 1'b1; fwd = 1'b0; rev_req = 1'b0; loaded = 1'b0; len = '0;
    for (int i = 0; i < 256; i++) img[i] = 5'd0;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("rst_pt_data", 32'(pt_data), 32'd0);
    chk("rst_strobe", 32'(pt_strobe), 32'd0);
    chk("rst_stop", 32'(pt_stop), 32'd0);
    chk("rst_rev", 32'(rev_o), 32'd0);
    chk("rst_pos", 32'(pt_pos), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_eot_unloaded", 32'(pt_eot), 32'd1);
    #1 rst = 1'b0;

    // Forward run over {1,2,STOP,3}
    img[0] = 5'd1; img[1] = 5'd2; img[2] = 5'd16; img[3] = 5'd3;
    len = 8'd4; loaded = 1'b1;
    @(negedge CLOCK);
    chk("eot_loaded", 32'(pt_eot), 32'd0);
    push_frame(5'd1); push_frame(5'd2); push_frame(5'd16); push_frame(5'd3);
    #1 fwd = 1'b1;
    wait_strobes(4, "fwd_run_strobes");
    for (int i = 1; i < 4; i++)
      chk("strobe_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'(CC));
    repeat (8) @(negedge CLOCK);
    chk("fwd_run_idle_count", 32'(strobe_cnt), 32'd4);
    chk("fwd_run_pos", 32'(pt_pos), 32'd4);
    chk("fwd_run_eot", 32'(pt_eot), 32'd1);
    chk("fwd_run_hold_data", 32'(pt_data), 32'd3);
    chk("fwd_run_rev", 32'(rev_o), 32'd0);
    #1 fwd = 1'b0;

    // FWD dropped two clocks into the second period
    reload();
    @(negedge CLOCK);
    chk("reload_pos", 32'(pt_pos), 32'd0);
    push_frame(5'd1);
    #1 fwd = 1'b1;
    wait_strobes(5, "abort_first_strobe");
    @(posedge CLOCK); #1 fwd = 1'b0;
    repeat (10) @(negedge CLOCK);
    chk("abort_no_strobe", 32'(strobe_cnt), 32'd5);
    chk("abort_pos", 32'(pt_pos), 32'd1);
    push_frame(5'd2);
    #1 fwd = 1'b1;
    wait_strobes(6, "abort_resume_strobe");
    @(posedge CLOCK); #1 fwd = 1'b0;
    repeat (6) @(negedge CLOCK);
    chk("abort_resume_pos", 32'(pt_pos), 32'd2);

    // Reverse one block over {1,STOP,2,3,STOP}
    img[0] = 5'd1; img[1] = 5'd16; img[2] = 5'd2; img[3] = 5'd3; img[4] = 5'd16;
    len = 8'd5;
    reload();
    push_frame(5'd1); push_frame(5'd16); push_frame(5'd2); push_frame(5'd3); push_frame(5'd16);
    #1 fwd = 1'b1;
    wait_strobes(11, "blk_fwd_strobes");
    repeat (3) @(posedge CLOCK);
    #1 fwd = 1'b0;
    @(negedge CLOCK);
    chk("blk_pos_end", 32'(pt_pos), 32'd5);
    sc = strobe_cnt;
    rev_measure(rc);
    chk("blk_rev_cycles", 32'(rc), 32'(4 * CC));
    chk("blk_rev_pos", 32'(pt_pos), 32'd2);
    chk("blk_rev_no_strobe", 32'(strobe_cnt), 32'(sc));
    push_frame(5'd2);
    #1 fwd = 1'b1;
    wait_strobes(sc + 1, "blk_after_rev_strobe");
    @(posedge CLOCK); #1 fwd = 1'b0;
    repeat (6) @(negedge CLOCK);
    chk("blk_after_rev_pos", 32'(pt_pos), 32'd3);

    // Reverse to beginning of tape over {1,2,3}
    img[0] = 5'd1; img[1] = 5'd2; img[2] = 5'd3;
    len = 8'd3;
    reload();
    push_frame(5'd1); push_frame(5'd2); push_frame(5'd3);
    #1 fwd = 1'b1;
    wait_strobes(strobe_cnt + 3, "bot_fwd_strobes");
    #1 fwd = 1'b0;
    @(negedge CLOCK);
    chk("bot_pos_end", 32'(pt_pos), 32'd3);
    sc = strobe_cnt;
    rev_measure(rc);
    chk("bot_rev_cycles", 32'(rc), 32'(3 * CC));
    chk("bot_rev_pos", 32'(pt_pos), 32'd0);
    chk("bot_rev_no_strobe", 32'(strobe_cnt), 32'(sc));

    // FWD and REV_REQ together: forward wins
    rt = rev_total;
    push_frame(5'd1);
    @(posedge CLOCK); #1 fwd = 1'b1; rev_req = 1'b1;
    wait_strobes(sc + 1, "both_strobe");
    @(posedge CLOCK); #1 fwd = 1'b0; rev_req = 1'b0;
    repeat (6) @(negedge CLOCK);
    chk("both_rev_never", 32'(rev_total - rt), 32'd0);
    chk("both_pos", 32'(pt_pos), 32'd1);

    // TAPE_LOADED dropped mid-reverse
    sc = strobe_cnt;
    @(posedge CLOCK); #1 rev_req = 1'b1;
    @(posedge CLOCK); #1 rev_req = 1'b0;
    @(negedge CLOCK);
    chk("unload_rev_started", 32'(rev_o), 32'd1);
    #1 loaded = 1'b0;
    @(posedge CLOCK);
    @(negedge CLOCK);
    chk("unload_rev", 32'(rev_o), 32'd0);
    chk("unload_pos", 32'(pt_pos), 32'd0);
    chk("unload_eot", 32'(pt_eot), 32'd1);
    #1 loaded = 1'b1;
    repeat (8) @(negedge CLOCK);
    chk("unload_no_strobe", 32'(strobe_cnt), 32'(sc));

    // rst during FWD_READ
    #1 fwd = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge CLOCK);
      if (mem_rd) begin
        hit = 1'b1;
        rst = 1'b1;
      end
    end
    chk("rst_read_reached", 32'(hit), 32'd1);
    @(posedge CLOCK); #1 rst = 1'b0; fwd = 1'b0;
    @(negedge CLOCK);
    chk("rst_mid_pos", 32'(pt_pos), 32'd0);
    chk("rst_mid_data", 32'(pt_data), 32'd0);
    chk("rst_mid_rev", 32'(rev_o), 32'd0);
    repeat (8) @(negedge CLOCK);
    chk("rst_mid_no_strobe", 32'(strobe_cnt), 32'(sc));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
